// File: rtl/perceptron_mac.sv
// perceptron_mac: single-neuron MAC with optional on-line training, built when PERCEPTRON_TRAIN_EN is defined.
// Latency is N_IN+1 cycles from accept to out_valid, or 2*N_IN+2 when a weight update runs.
// One sample in flight: in_ready is high only in IDLE; the result is held in DONE until out_ready.

module perceptron_mac #(
   parameter  int N_IN     = 4,
   parameter  int IN_W     = 8,
   parameter  int WT_W     = 8,
   parameter  int LR_SHIFT = 0,
   localparam int ACC_W    = IN_W + WT_W + $clog2(N_IN + 1),
   localparam int AW       = $clog2(N_IN + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_IN*IN_W-1:0]   x_vec,
   input  logic                   train,
   input  logic                   target,
   input  logic                   wt_we,
   input  logic [AW-1:0]          wt_addr,
   input  logic signed [WT_W-1:0] wt_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   classification,
   output logic signed [ACC_W-1:0] acc_out,
   output logic                   updated
);

   localparam int IDX_W = $clog2(N_IN);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MAC    = 2'd1,
      DONE   = 2'd2
`ifdef PERCEPTRON_TRAIN_EN
      ,
      UPDATE = 2'd3
`endif
   } state_t;

   state_t state, state_nxt;

   logic signed [WT_W-1:0]  wt [N_IN];
   logic signed [WT_W-1:0]  bias;
   logic [IN_W-1:0]         x_lat [N_IN];
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [ACC_W-1:0] prod;
   logic signed [ACC_W-1:0] x_ext;
   logic signed [ACC_W-1:0] w_ext;
   logic signed [ACC_W-1:0] bias_ext;
   logic [IDX_W-1:0]        ch;
   logic                    aux;   // MAC: bias-load cycle pending; UPDATE: bias-step cycle pending
   logic                    ch_last;
   logic                    cls_nxt;

   // Inputs are unsigned, so zero-extend before the signed multiply.
   assign x_ext    = $signed({{(ACC_W-IN_W){1'b0}}, x_lat[ch]});
   assign w_ext    = {{(ACC_W-WT_W){wt[ch][WT_W-1]}}, wt[ch]};
   assign bias_ext = {{(ACC_W-WT_W){bias[WT_W-1]}}, bias};
   assign prod     = x_ext * w_ext;
   assign acc_sum  = acc + prod;
   assign cls_nxt  = ~acc_sum[ACC_W-1];
   assign ch_last  = (ch == IDX_W'(N_IN - 1));

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

`ifdef PERCEPTRON_TRAIN_EN
   localparam int WT_MAX_I = (2 ** (WT_W - 1)) - 1;
   localparam int WT_MIN_I = -(2 ** (WT_W - 1));
   localparam int SUM_W    = ((IN_W > WT_W) ? IN_W : WT_W) + 2;
   localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(WT_MAX_I);
   localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(WT_MIN_I);
   localparam logic signed [WT_W-1:0]  WT_MAX  = WT_W'(WT_MAX_I);
   localparam logic signed [WT_W-1:0]  WT_MIN  = WT_W'(WT_MIN_I);

   logic train_lat;
   logic target_lat;
   logic upd_q;
   logic upd_need;

   // Widened add/subtract then clamp, so a step can never wrap.
   function automatic logic signed [WT_W-1:0] sat_step(
      input logic signed [WT_W-1:0] w,
      input logic [IN_W-1:0]        mag,
      input logic                   up
   );
      logic signed [SUM_W-1:0] w_e;
      logic signed [SUM_W-1:0] m_e;
      logic signed [SUM_W-1:0] s;
      w_e = {{(SUM_W-WT_W){w[WT_W-1]}}, w};
      m_e = $signed({{(SUM_W-IN_W){1'b0}}, mag});
      s   = up ? (w_e + m_e) : (w_e - m_e);
      if (s > SUM_MAX)
         return WT_MAX;
      else if (s < SUM_MIN)
         return WT_MIN;
      else
         return s[WT_W-1:0];
   endfunction

   assign upd_need = train_lat && (cls_nxt != target_lat);
   assign updated  = upd_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^{train, target, 32'(LR_SHIFT)};
   assign updated    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = MAC;
         MAC: begin
            if (!aux && ch_last) begin
`ifdef PERCEPTRON_TRAIN_EN
               state_nxt = upd_need ? UPDATE : DONE;
`else
               state_nxt = DONE;
`endif
            end
         end
`ifdef PERCEPTRON_TRAIN_EN
         UPDATE: if (aux) state_nxt = DONE;
`endif
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_IN; i++) begin
            wt[i]    <= '0;
            x_lat[i] <= '0;
         end
         bias           <= '0;
         acc            <= '0;
         ch             <= '0;
         aux            <= 1'b0;
         acc_out        <= '0;
         classification <= 1'b0;
`ifdef PERCEPTRON_TRAIN_EN
         train_lat      <= 1'b0;
         target_lat     <= 1'b0;
         upd_q          <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // Write lands before the accepted sample reads any weight.
               if (wt_we) begin
                  if (wt_addr < AW'(N_IN))
                     wt[wt_addr[IDX_W-1:0]] <= wt_data;
                  else if (wt_addr == AW'(N_IN))
                     bias <= wt_data;
               end
               if (in_valid) begin
                  for (int i = 0; i < N_IN; i++)
                     x_lat[i] <= x_vec[i*IN_W +: IN_W];
`ifdef PERCEPTRON_TRAIN_EN
                  train_lat  <= train;
                  target_lat <= target;
`endif
                  aux <= 1'b1;
                  ch  <= '0;
               end
            end
            MAC: begin
               if (aux) begin
                  acc <= bias_ext;
                  aux <= 1'b0;
               end else begin
                  acc <= acc_sum;
                  ch  <= ch + 1'b1;
                  if (ch_last) begin
                     ch             <= '0;
                     acc_out        <= acc_sum;
                     classification <= cls_nxt;
`ifdef PERCEPTRON_TRAIN_EN
                     upd_q          <= upd_need;
`endif
                  end
               end
            end
`ifdef PERCEPTRON_TRAIN_EN
            UPDATE: begin
               if (!aux) begin
                  wt[ch] <= sat_step(wt[ch], x_lat[ch] >> LR_SHIFT, target_lat);
                  ch     <= ch + 1'b1;
                  if (ch_last) begin
                     ch  <= '0;
                     aux <= 1'b1;
                  end
               end else begin
                  bias <= sat_step(bias, IN_W'(1), target_lat);
                  aux  <= 1'b0;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_perceptron_mac.sv
// Bench for perceptron_mac: random and directed samples against an integer model of the neuron.

module tb_perceptron_mac;

   localparam int N_IN     = 4;
   localparam int IN_W     = 8;
   localparam int WT_W     = 8;
   localparam int LR_SHIFT = 0;
   localparam int ACC_W    = IN_W + WT_W + $clog2(N_IN + 1);
   localparam int AW       = $clog2(N_IN + 1);
`ifdef PERCEPTRON_TRAIN_EN
   localparam bit TRAIN_EN = 1'b1;
`else
   localparam bit TRAIN_EN = 1'b0;
`endif

   logic                    clk;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [N_IN*IN_W-1:0]    x_vec;
   logic                    train;
   logic                    target;
   logic                    wt_we;
   logic [AW-1:0]           wt_addr;
   logic signed [WT_W-1:0]  wt_data;
   logic                    out_valid;
   logic                    out_ready;
   logic                    classification;
   logic signed [ACC_W-1:0] acc_out;
   logic                    updated;

   int checks = 0;
   int errors = 0;
   int w_m[N_IN];
   int b_m;

   perceptron_mac #(.N_IN(N_IN), .IN_W(IN_W), .WT_W(WT_W), .LR_SHIFT(LR_SHIFT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_vec(x_vec),
      .train(train), .target(target), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
      .out_valid(out_valid), .out_ready(out_ready), .classification(classification),
      .acc_out(acc_out), .updated(updated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int clamp_w(input int v);
      int hi = (1 << (WT_W - 1)) - 1;
      int lo = -(1 << (WT_W - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N_IN; i++) w_m[i] = 0;
      b_m = 0;
   endtask

   task automatic wr(input int addr, input int data);
      wt_we = 1'b1; wt_addr = AW'(addr); wt_data = WT_W'(data);
      @(posedge clk); #1;
      wt_we = 1'b0;
      if (addr < N_IN) w_m[addr] = data;
      else if (addr == N_IN) b_m = data;
   endtask

   // One full transaction; expectations come from the model, which then applies any training step.
   task automatic run_sample(input string tag, input logic [N_IN*IN_W-1:0] xv,
                             input bit tr, input bit tg, output int got_acc);
      int exp_acc, exp_lat, n, xi;
      bit exp_cls, exp_upd;
      exp_acc = b_m;
      for (int i = 0; i < N_IN; i++) exp_acc += w_m[i] * int'(xv[i*IN_W +: IN_W]);
      exp_cls = (exp_acc >= 0);
      exp_upd = TRAIN_EN && tr && (exp_cls != tg);
      exp_lat = exp_upd ? 2*N_IN + 2 : N_IN + 1;

      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL %s in_ready_idle: got %b expected 1", tag, in_ready);
      end
      x_vec = xv; train = tr; target = tg; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; train = 1'b0; target = 1'b0; wt_we = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n != exp_lat) begin
         errors++; $display("FAIL %s latency: got %0d expected %0d", tag, n, exp_lat);
      end
      got_acc = $signed(acc_out);
      checks++;
      if (got_acc !== exp_acc) begin
         errors++; $display("FAIL %s acc_out: got %0d expected %0d", tag, got_acc, exp_acc);
      end
      checks++;
      if (classification !== exp_cls) begin
         errors++; $display("FAIL %s classification: got %b expected %b", tag, classification, exp_cls);
      end
      checks++;
      if (updated !== exp_upd) begin
         errors++; $display("FAIL %s updated: got %b expected %b", tag, updated, exp_upd);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL %s consume: got in_ready=%b out_valid=%b expected 1/0", tag, in_ready, out_valid);
      end
      if (exp_upd) begin
         for (int i = 0; i < N_IN; i++) begin
            xi = int'(xv[i*IN_W +: IN_W]) >> LR_SHIFT;
            w_m[i] = clamp_w(tg ? w_m[i] + xi : w_m[i] - xi);
         end
         b_m = clamp_w(tg ? b_m + 1 : b_m - 1);
      end
   endtask

   // Inference with one-hot unit inputs exposes each stored weight and the bias.
   task automatic read_back(input string tag);
      int got_b, got;
      logic [N_IN*IN_W-1:0] xv;
      run_sample({tag, "_rb_bias"}, '0, 1'b0, 1'b0, got_b);
      checks++;
      if (got_b !== b_m) begin
         errors++; $display("FAIL %s bias: got %0d expected %0d", tag, got_b, b_m);
      end
      for (int i = 0; i < N_IN; i++) begin
         xv = '0;
         xv[i*IN_W +: IN_W] = IN_W'(1);
         run_sample({tag, "_rb_w"}, xv, 1'b0, 1'b0, got);
         checks++;
         if (got - got_b !== w_m[i]) begin
            errors++; $display("FAIL %s w%0d: got %0d expected %0d", tag, i, got - got_b, w_m[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || acc_out !== '0 || classification !== 1'b0 || updated !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: got out_valid=%b acc=%0d cls=%b upd=%b expected 0/0/0/0",
                  out_valid, acc_out, classification, updated);
      end
      rst = 1'b0;
      model_clear();
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_out !== '0) begin
         errors++;
         $display("FAIL reset_release: got in_ready=%b out_valid=%b acc=%0d expected 1/0/0",
                  in_ready, out_valid, acc_out);
      end
   endtask

   task automatic test_zero();
      int got;
      run_sample("zero_x", '0, 1'b0, 1'b0, got);
   endtask

   task automatic test_directed();
      int got;
      wr(0, 1); wr(1, 2); wr(2, -1); wr(3, 0); wr(4, -10);
      run_sample("infer", {8'd9, 8'd5, 8'd4, 8'd3}, 1'b0, 1'b0, got);
      checks++;
      if (got !== -4) begin
         errors++; $display("FAIL infer_const: got %0d expected -4", got);
      end
      run_sample("train", {8'd9, 8'd5, 8'd4, 8'd3}, 1'b1, 1'b1, got);
      read_back("train");
   endtask

   task automatic test_saturation();
      int got;
      wr(0, 120); wr(1, -128); wr(2, 0); wr(3, 0); wr(4, 0);
      run_sample("sat_hi", {8'd0, 8'd0, 8'd255, 8'd20}, 1'b1, 1'b1, got);
      read_back("sat_hi");
      wr(0, -120); wr(1, 127); wr(2, 0); wr(3, 0); wr(4, 0);
      run_sample("sat_lo", {8'd0, 8'd0, 8'd255, 8'd20}, 1'b1, 1'b0, got);
      read_back("sat_lo");
   endtask

   task automatic test_hold();
      logic signed [ACC_W-1:0] cap_acc;
      logic cap_cls, cap_upd;
      int exp_acc, n;
      logic [N_IN*IN_W-1:0] xv;
      wr(0, 5); wr(1, -3); wr(4, 2);
      xv = {8'd9, 8'd1, 8'd7, 8'd4};
      exp_acc = b_m;
      for (int i = 0; i < N_IN; i++) exp_acc += w_m[i] * int'(xv[i*IN_W +: IN_W]);
      x_vec = xv; train = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n != N_IN + 1 || $signed(acc_out) !== exp_acc) begin
         errors++; $display("FAIL hold_result: got lat=%0d acc=%0d expected %0d/%0d", n, acc_out, N_IN + 1, exp_acc);
      end
      cap_acc = acc_out; cap_cls = classification; cap_upd = updated;
      for (int k = 0; k < 7; k++) begin
         wt_we = 1'b1; wt_addr = AW'(0); wt_data = WT_W'(77); in_valid = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== cap_acc ||
             classification !== cap_cls || updated !== cap_upd) begin
            errors++;
            $display("FAIL hold_stable cycle %0d: got valid=%b rdy=%b acc=%0d expected 1/0/%0d",
                     k, out_valid, in_ready, acc_out, cap_acc);
         end
      end
      wt_we = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL hold_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
      read_back("hold");
   endtask

   task automatic test_reset_mid();
      int got;
      bit seen;
      wr(0, 10); wr(1, -20); wr(2, 30); wr(3, 40); wr(4, 7);
      x_vec = {8'd1, 8'd2, 8'd3, 8'd4}; train = 1'b1; target = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; train = 1'b0; target = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc_out !== '0) begin
         errors++;
         $display("FAIL rst_mid_abort: got out_valid=%b in_ready=%b acc=%0d expected 0/1/0", out_valid, in_ready, acc_out);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL rst_mid_no_result: got out_valid seen=1 expected 0");
      end
      read_back("rst_mid");
      run_sample("after_rst", {8'd200, 8'd3, 8'd17, 8'd99}, 1'b1, 1'b0, got);
   endtask

   task automatic test_back_to_back();
      int got;
      wr(0, 3); wr(1, 4); wr(2, 5); wr(3, 6); wr(4, -1);
      wt_we = 1'b1; wt_addr = AW'(2); wt_data = WT_W'(-50);
      w_m[2] = -50;
      run_sample("same_edge", {8'd2, 8'd10, 8'd1, 8'd1}, 1'b0, 1'b0, got);
      wr(5, 33); wr(6, -7); wr(7, 100);
      read_back("bad_addr");
      run_sample("b2b_a", {8'd1, 8'd1, 8'd1, 8'd1}, 1'b1, 1'b1, got);
      run_sample("b2b_b", {8'd7, 8'd0, 8'd250, 8'd1}, 1'b1, 1'b0, got);
   endtask

   task automatic test_random();
      int got;
      logic [N_IN*IN_W-1:0] xv;
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 2) == 0)
            wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
         for (int i = 0; i < N_IN; i++) xv[i*IN_W +: IN_W] = IN_W'($urandom_range(0, 255));
         run_sample("random", xv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got);
         if (it % 10 == 9) read_back("random");
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; x_vec = '0; train = 1'b0; target = 1'b0;
      wt_we = 1'b0; wt_addr = '0; wt_data = '0; out_ready = 1'b0;
      model_clear();
      test_reset();
      test_zero();
      test_directed();
      test_saturation();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
